// File: rtl/shift_arbiter_if.sv
// Handshake bundle for shift_arbiter: two request ports plus one response port.
// The slave modport is the arbiter side, the master modport is the requester/consumer side.
interface shift_arbiter_if;
   logic        i_req0_valid;
   logic        o_req0_ready;
   logic [31:0] i_req0_a;
   logic [4:0]  i_req0_shamt;
   logic [1:0]  i_req0_mode;
   logic        i_req1_valid;
   logic        o_req1_ready;
   logic [31:0] i_req1_a;
   logic [4:0]  i_req1_shamt;
   logic [1:0]  i_req1_mode;
   logic        o_rsp_valid;
   logic        i_rsp_ready;
   logic [31:0] o_rsp_y;
   logic        o_rsp_id;

   modport slave (
      input  i_req0_valid, i_req0_a, i_req0_shamt, i_req0_mode,
      input  i_req1_valid, i_req1_a, i_req1_shamt, i_req1_mode,
      input  i_rsp_ready,
      output o_req0_ready, o_req1_ready,
      output o_rsp_valid, o_rsp_y, o_rsp_id
   );

   modport master (
      output i_req0_valid, i_req0_a, i_req0_shamt, i_req0_mode,
      output i_req1_valid, i_req1_a, i_req1_shamt, i_req1_mode,
      output i_rsp_ready,
      input  o_req0_ready, o_req1_ready,
      input  o_rsp_valid, o_rsp_y, o_rsp_id
   );
endinterface

// File: rtl/shift_arbiter.sv
// Two-port arbiter sharing one 32-bit barrel shifter through a two-stage pipeline.
// Define SHIFT_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module shift_arbiter (
   input logic            i_clk,
   input logic            i_reset,
   shift_arbiter_if.slave bus
);

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;

   logic        s1Valid;
   logic [31:0] s1A;
   logic [4:0]  s1Shamt;
   logic [1:0]  s1Mode;
   logic        s1Id;
   logic        s2Valid;
   logic [31:0] s2Y;
   logic        s2Id;
   logic        s2Load;
   logic        s1Load;
   logic        grant0;
   logic        grant1;
   logic [31:0] shiftY;

   assign s2Load = !s2Valid || bus.i_rsp_ready;
   assign s1Load = !s1Valid || s2Load;

`ifdef SHIFT_ARB_RR_EN
   logic lastGrant;

   // On a tie the port that did not win most recently goes first.
   assign grant0 = i_reset && s1Load && bus.i_req0_valid && (!bus.i_req1_valid || lastGrant);
   assign grant1 = i_reset && s1Load && bus.i_req1_valid && (!bus.i_req0_valid || !lastGrant);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         lastGrant <= 1'b1;
      end else if (grant0 || grant1) begin
         lastGrant <= grant1;
      end
   end
`else
   assign grant0 = i_reset && s1Load && bus.i_req0_valid;
   assign grant1 = i_reset && s1Load && bus.i_req1_valid && !bus.i_req0_valid;
`endif

   assign bus.o_req0_ready = grant0;
   assign bus.o_req1_ready = grant1;

   always_comb begin
      shiftY = s1A;
      case (s1Mode)
         MODE_SLL: shiftY = s1A << s1Shamt;
         MODE_SRL: shiftY = s1A >> s1Shamt;
         default:  shiftY = $unsigned($signed(s1A) >>> s1Shamt);
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         s1Valid <= 1'b0;
         s1A     <= '0;
         s1Shamt <= '0;
         s1Mode  <= '0;
         s1Id    <= 1'b0;
      end else if (s1Load) begin
         s1Valid <= grant0 || grant1;
         if (grant0) begin
            s1A     <= bus.i_req0_a;
            s1Shamt <= bus.i_req0_shamt;
            s1Mode  <= bus.i_req0_mode;
            s1Id    <= 1'b0;
         end else if (grant1) begin
            s1A     <= bus.i_req1_a;
            s1Shamt <= bus.i_req1_shamt;
            s1Mode  <= bus.i_req1_mode;
            s1Id    <= 1'b1;
         end
      end
   end

   // S2 holds its result while the consumer stalls, so the response stays stable.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         s2Valid <= 1'b0;
         s2Y     <= '0;
         s2Id    <= 1'b0;
      end else if (s2Load) begin
         s2Valid <= s1Valid;
         s2Y     <= shiftY;
         s2Id    <= s1Id;
      end
   end

   assign bus.o_rsp_valid = s2Valid;
   assign bus.o_rsp_y     = s2Y;
   assign bus.o_rsp_id    = s2Id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// checked against an occupancy/queue reference model.
module tb_shift_arbiter;

   logic clk  = 1'b0;
   logic rstN = 1'b1;
   always #5 clk = ~clk;

   shift_arbiter_if bus ();

   shift_arbiter dut (
      .i_clk   (clk),
      .i_reset (rstN),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [31:0] y;
      logic        id;
      int          acc;
   } expT;

   expT         expQ[$];
   logic [31:0] logY[$];
   logic        logId[$];
   int          logCyc[$];
   int          cycleNum = 0;
   int          checks   = 0;
   int          fails    = 0;
   int          accCount = 0;
   logic        lastG0   = 1'b0;
   logic        lastG1   = 1'b0;
`ifdef SHIFT_ARB_RR_EN
   logic        lastGrant = 1'b1;
`endif

   logic        pv[2];
   logic [31:0] pa[2];
   logic [4:0]  ps[2];
   logic [1:0]  pm[2];
   logic        rndReady;
   int          tieIds[4];

   // Reference shift done with multiply/divide by powers of two.
   function automatic logic [31:0] refShift(input logic [31:0] a, input logic [4:0] sh,
                                            input logic [1:0] mode);
      longint unsigned p   = 1;
      longint unsigned ua  = {32'd0, a};
      longint unsigned nua = {32'd0, ~a};
      for (int i = 0; i < int'(sh); i++) p = p * 2;
      if (mode == 2'b00) return 32'((ua * p) % 64'h1_0000_0000);
      if (mode == 2'b01 || !a[31]) return 32'(ua / p);
      return ~(32'(nua / p));
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] yAt(input int i);
      return (i < logY.size()) ? logY[i] : 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] idAt(input int i);
      return (i < logId.size()) ? 32'(logId[i]) : 32'hxxxxxxxx;
   endfunction

   function automatic logic [31:0] cycAt(input int i);
      return (i < logCyc.size()) ? 32'(logCyc[i] - logCyc[0]) : 32'hxxxxxxxx;
   endfunction

   task automatic clearLog();
      logY.delete();
      logId.delete();
      logCyc.delete();
   endtask

   // One clock cycle: drive at negedge, compare against the model, advance the model at posedge.
   task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [4:0] s0,
                                input logic [1:0] m0, input logic v1, input logic [31:0] a1,
                                input logic [4:0] s1, input logic [1:0] m1, input logic rr);
      logic canAcc;
      logic g0;
      logic g1;
      logic expValid;
      @(negedge clk);
      bus.i_req0_valid = v0;
      bus.i_req0_a     = a0;
      bus.i_req0_shamt = s0;
      bus.i_req0_mode  = m0;
      bus.i_req1_valid = v1;
      bus.i_req1_a     = a1;
      bus.i_req1_shamt = s1;
      bus.i_req1_mode  = m1;
      bus.i_rsp_ready  = rr;
      #1;
      canAcc = (expQ.size() < 2) || rr;
`ifdef SHIFT_ARB_RR_EN
      g0 = canAcc && v0 && (!v1 || lastGrant);
      g1 = canAcc && v1 && (!v0 || !lastGrant);
`else
      g0 = canAcc && v0;
      g1 = canAcc && v1 && !v0;
`endif
      expValid = (expQ.size() > 0) && (cycleNum >= expQ[0].acc + 2);
      checkOutput("ready0", 32'(bus.o_req0_ready), 32'(g0));
      checkOutput("ready1", 32'(bus.o_req1_ready), 32'(g1));
      checkOutput("rsp_valid", 32'(bus.o_rsp_valid), 32'(expValid));
      if (expValid) begin
         checkOutput("rsp_y", bus.o_rsp_y, expQ[0].y);
         checkOutput("rsp_id", 32'(bus.o_rsp_id), 32'(expQ[0].id));
      end
      if (bus.o_rsp_valid && rr) begin
         logY.push_back(bus.o_rsp_y);
         logId.push_back(bus.o_rsp_id);
         logCyc.push_back(cycleNum);
      end
      if ((v0 && bus.o_req0_ready) || (v1 && bus.o_req1_ready)) accCount++;
      lastG0 = g0;
      lastG1 = g1;
      @(posedge clk);
      if (expValid && rr) void'(expQ.pop_front());
      if (g0) expQ.push_back('{refShift(a0, s0, m0), 1'b0, cycleNum});
      else if (g1) expQ.push_back('{refShift(a1, s1, m1), 1'b1, cycleNum});
`ifdef SHIFT_ARB_RR_EN
      if (g0 || g1) lastGrant = g1;
`endif
      cycleNum++;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
   endtask

   // Asynchronous reset mid-cycle with both ports requesting; readies must stay low.
   task automatic applyReset();
      @(negedge clk);
      bus.i_req0_valid = 1'b1;
      bus.i_req1_valid = 1'b1;
      bus.i_rsp_ready  = 1'b0;
      #2 rstN = 1'b0;
      #1;
      checkOutput("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      checkOutput("reset_rsp_y", bus.o_rsp_y, 32'd0);
      checkOutput("reset_rsp_id", 32'(bus.o_rsp_id), 32'd0);
      checkOutput("reset_ready0", 32'(bus.o_req0_ready), 32'd0);
      checkOutput("reset_ready1", 32'(bus.o_req1_ready), 32'd0);
      expQ.delete();
`ifdef SHIFT_ARB_RR_EN
      lastGrant = 1'b1;
`endif
      @(negedge clk);
      @(negedge clk);
      bus.i_req0_valid = 1'b0;
      bus.i_req1_valid = 1'b0;
      bus.i_rsp_ready  = 1'b1;
      rstN = 1'b1;
   endtask

   initial begin
      bus.i_req0_valid = 1'b0;
      bus.i_req0_a     = '0;
      bus.i_req0_shamt = '0;
      bus.i_req0_mode  = '0;
      bus.i_req1_valid = 1'b0;
      bus.i_req1_a     = '0;
      bus.i_req1_shamt = '0;
      bus.i_req1_mode  = '0;
      bus.i_rsp_ready  = 1'b1;
      pv[0] = 1'b0;
      pv[1] = 1'b0;

      applyReset();

      $display("[TB] basic shifts");
      clearLog();
      applyStimulus(1'b1, 32'h0000_0001, 5'd31, 2'b00, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      applyStimulus(1'b1, 32'h8000_0000, 5'd4,  2'b10, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      applyStimulus(1'b1, 32'h8000_0000, 5'd4,  2'b11, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      applyStimulus(1'b1, 32'h8000_0000, 5'd4,  2'b01, 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      repeat (3) idle();
      checkOutput("basic_sll", yAt(0), 32'h8000_0000);
      checkOutput("basic_sra", yAt(1), 32'hF800_0000);
      checkOutput("basic_sra11", yAt(2), 32'hF800_0000);
      checkOutput("basic_srl", yAt(3), 32'h0800_0000);
      for (int i = 0; i < 4; i++) checkOutput($sformatf("basic_id%0d", i), idAt(i), 32'd0);

      $display("[TB] tie arbitration");
      applyReset();
      clearLog();
`ifdef SHIFT_ARB_RR_EN
      tieIds = '{0, 1, 0, 1};
`else
      tieIds = '{0, 0, 0, 0};
`endif
      repeat (4) applyStimulus(1'b1, 32'h1, 5'd1, 2'b00, 1'b1, 32'h1, 5'd2, 2'b00, 1'b1);
      repeat (3) idle();
      for (int i = 0; i < 4; i++) checkOutput($sformatf("tie_id%0d", i), idAt(i), 32'(tieIds[i]));

      $display("[TB] backpressure");
      clearLog();
      accCount = 0;
      repeat (5) applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 32'h0000_F000, 5'd8, 2'b01, 1'b0);
      checkOutput("bp_accepts", 32'(accCount), 32'd2);
      checkOutput("bp_hold_y", bus.o_rsp_y, 32'h0000_00F0);
      checkOutput("bp_hold_id", 32'(bus.o_rsp_id), 32'd1);
      repeat (3) applyStimulus(1'b0, 32'd0, 5'd0, 2'd0, 1'b1, 32'h0000_F000, 5'd8, 2'b01, 1'b1);
      repeat (3) idle();
      checkOutput("bp_drained", 32'(logY.size()), 32'd5);
      for (int i = 0; i < 5; i++) checkOutput($sformatf("bp_y%0d", i), yAt(i), 32'h0000_00F0);

      $display("[TB] pass-through");
      clearLog();
      for (int m = 0; m < 4; m++)
         applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd0, 2'(m), 1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
      repeat (3) idle();
      for (int i = 0; i < 4; i++) checkOutput($sformatf("pass_y%0d", i), yAt(i), 32'hDEAD_BEEF);

      $display("[TB] full throughput");
      clearLog();
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0)
            applyStimulus(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                          1'b0, 32'd0, 5'd0, 2'd0, 1'b1);
         else
            applyStimulus(1'b0, 32'd0, 5'd0, 2'd0,
                          1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
      end
      repeat (3) idle();
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("tput_id%0d", i), idAt(i), 32'(i % 2));
         checkOutput($sformatf("tput_cyc%0d", i), cycAt(i), 32'(i));
      end

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p]) begin
               pv[p] = ($urandom_range(0, 9) < 6);
               pa[p] = $urandom;
               case ($urandom_range(0, 3))
                  0:       ps[p] = 5'd0;
                  1:       ps[p] = 5'd31;
                  default: ps[p] = 5'($urandom_range(0, 31));
               endcase
               pm[p] = 2'($urandom_range(0, 3));
            end
         end
         rndReady = ($urandom_range(0, 9) < 7);
         applyStimulus(pv[0], pa[0], ps[0], pm[0], pv[1], pa[1], ps[1], pm[1], rndReady);
         if (lastG0) pv[0] = 1'b0;
         if (lastG1) pv[1] = 1'b0;
      end
      repeat (3) idle();

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 32'h1234_5678, 5'd4, 2'b00, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0);
      applyStimulus(1'b1, 32'h1234_5678, 5'd8, 2'b00, 1'b0, 32'd0, 5'd0, 2'd0, 1'b0);
      applyReset();
      clearLog();
      applyStimulus(1'b1, 32'h5, 5'd1, 2'b00, 1'b1, 32'h5, 5'd2, 2'b00, 1'b1);
      repeat (3) idle();
      checkOutput("post_reset_tie_id", idAt(0), 32'd0);
      checkOutput("post_reset_tie_y", yAt(0), 32'h0000_000A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
